// File: rtl/bounce_pattern_decoder.sv
// Receive-side decoder for the bouncing one-hot pattern bus: recovers position, direction,
// end events and lock status. Optional sticky error register under BOUNCE_DEC_STICKY_ERR_EN.
module bounce_pattern_decoder #(
  parameter int N        = 8,
  parameter int PERIOD_W = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         q_in,
  input  logic                 clr_err,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 locked,
  output logic                 lsb_hit,
  output logic                 msb_hit,
  output logic [PERIOD_W-1:0]  period_count,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [2:0]           err_sticky
);
  localparam int PW = $clog2(N);
  localparam int CW = 4;
  localparam logic [PW-1:0] POS_MAX  = PW'(N - 1);
  localparam logic [CW-1:0] LOCK_TGT = CW'(LOCK_CNT);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_HOT  = 2'b01;
  localparam logic [1:0] CODE_JUMP = 2'b10;
  localparam logic [1:0] CODE_REV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_TRACK, S_LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  function automatic logic [PW-1:0] hot_index(input logic [N-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [CW-1:0]         good_q, good_d;
  logic [PERIOD_W-1:0]   per_q, per_d;
  logic                  locked_q, locked_d;
  logic                  lsb_q, lsb_d;
  logic                  msb_q, msb_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic                  legal;
  logic [PW-1:0]         smp;
  logic [PW-1:0]         exp_pos;
  logic [PW-1:0]         prev_pos;
  logic                  at_mid;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    good_d   = good_q;
    per_d    = per_q;
    lsb_d    = 1'b0;
    msb_d    = 1'b0;
    err_d    = 1'b0;
    code_d   = CODE_NONE;
    legal    = $onehot(q_in);
    smp      = hot_index(q_in);
    at_mid   = (pos_q != '0) && (pos_q != POS_MAX);
    prev_pos = dir_q ? pos_q + PW'(1) : pos_q - PW'(1);
    // At either end the pattern bounces, so the expected move reverses there.
    if (dir_q) exp_pos = (pos_q != '0) ? pos_q - PW'(1) : PW'(1);
    else       exp_pos = (pos_q != POS_MAX) ? pos_q + PW'(1) : POS_MAX - PW'(1);

    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          good_d = '0;
          if (legal) begin
            pos_d   = smp;
            state_d = S_ACQ;
          end else begin
            err_d  = 1'b1;
            code_d = CODE_HOT;
          end
        end
        S_ACQ: begin
          good_d = '0;
          if (!legal) begin
            err_d   = 1'b1;
            code_d  = CODE_HOT;
            state_d = S_IDLE;
          end else if ((pos_q != '0) && (smp == pos_q - PW'(1))) begin
            pos_d   = smp;
            dir_d   = 1'b1;
            lsb_d   = (smp == '0);
            state_d = S_TRACK;
          end else if ((pos_q != POS_MAX) && (smp == pos_q + PW'(1))) begin
            pos_d   = smp;
            dir_d   = 1'b0;
            msb_d   = (smp == POS_MAX);
            state_d = S_TRACK;
          end else begin
            err_d  = 1'b1;
            code_d = CODE_JUMP;
            pos_d  = smp;
          end
        end
        default: begin
          if (legal && (smp == exp_pos)) begin
            pos_d = smp;
            if (pos_q == '0)          dir_d = 1'b0;
            else if (pos_q == POS_MAX) dir_d = 1'b1;
            lsb_d = dir_q && (smp == '0);
            msb_d = !dir_q && (smp == POS_MAX);
            if (lsb_d) per_d = per_q + PERIOD_W'(1);
            if (state_q == S_TRACK) begin
              good_d = sat_inc(good_q);
              if (good_d >= LOCK_TGT) state_d = S_LOCKED;
            end
          end else begin
            err_d  = 1'b1;
            good_d = '0;
            if (!legal) begin
              code_d  = CODE_HOT;
              state_d = S_IDLE;
            end else begin
              code_d  = (at_mid && (smp == prev_pos)) ? CODE_REV : CODE_JUMP;
              pos_d   = smp;
              state_d = S_ACQ;
            end
          end
        end
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      dir_q    <= 1'b1;
      good_q   <= '0;
      per_q    <= '0;
      locked_q <= 1'b0;
      lsb_q    <= 1'b0;
      msb_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= CODE_NONE;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      good_q   <= good_d;
      per_q    <= per_d;
      locked_q <= locked_d;
      lsb_q    <= lsb_d;
      msb_q    <= msb_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

`ifdef BOUNCE_DEC_STICKY_ERR_EN
  logic [2:0] sticky_q, sticky_d, flag;

  // A clear and a new error on the same edge leave only the new error's flag.
  always_comb begin
    flag = 3'b000;
    if (err_d) begin
      unique case (code_d)
        CODE_HOT:  flag = 3'b001;
        CODE_JUMP: flag = 3'b010;
        CODE_REV:  flag = 3'b100;
        default:   flag = 3'b000;
      endcase
    end
    sticky_d = (clr_err ? 3'b000 : sticky_q) | flag;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 3'b000;
    else     sticky_q <= sticky_d;
  end

  assign err_sticky = sticky_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_sticky     = 3'b000;
`endif

  assign pos          = pos_q;
  assign dir          = dir_q;
  assign locked       = locked_q;
  assign lsb_hit      = lsb_q;
  assign msb_hit      = msb_q;
  assign period_count = per_q;
  assign err          = err_q;
  assign err_code     = code_q;
endmodule

// File: tb/tb_bounce_pattern_decoder.sv
// Bench for bounce_pattern_decoder: directed vector table, corner-case sequences and a
// randomized run, all checked against a position/direction reference model.
module tb_bounce_pattern_decoder;
  localparam int N        = 8;
  localparam int PERIOD_W = 2;
  localparam int LOCK_CNT = 4;
`ifdef BOUNCE_DEC_STICKY_ERR_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ena = 1'b0;
  logic [N-1:0]        q_in = '0;
  logic                clr_err = 1'b0;
  logic [2:0]          pos;
  logic                dir, locked, lsb_hit, msb_hit, err;
  logic [PERIOD_W-1:0] period_count;
  logic [1:0]          err_code;
  logic [2:0]          err_sticky;

  bounce_pattern_decoder #(.N(N), .PERIOD_W(PERIOD_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .q_in(q_in), .clr_err(clr_err),
    .pos(pos), .dir(dir), .locked(locked), .lsb_hit(lsb_hit), .msb_hit(msb_hit),
    .period_count(period_count), .err(err), .err_code(err_code), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 acquiring, 2 tracking, 3 locked.
  int       m_st, m_pos, m_good, m_per;
  bit       m_dir;
  bit [2:0] m_sticky;
  bit       e_lsb, e_msb, e_err;
  int       e_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_dir = 1'b1; m_good = 0; m_per = 0; m_sticky = 3'b000;
    e_lsb = 0; e_msb = 0; e_err = 0; e_code = 0;
  endtask

  task automatic model_step(input bit en, input bit [7:0] q, input bit clr);
    int k, step, nxt;
    bit ok;
    e_lsb = 0; e_msb = 0; e_err = 0; e_code = 0;
    if (en) begin
      ok = ($countones(q) == 1);
      k  = -1;
      for (int i = 0; i < N; i++) if (q[i]) k = i;
      if (m_st == 0) begin
        if (ok) begin m_pos = k; m_st = 1; end
        else begin e_err = 1; e_code = 1; end
      end else if (m_st == 1) begin
        m_good = 0;
        if (!ok) begin e_err = 1; e_code = 1; m_st = 0; end
        else if (k == m_pos - 1 || k == m_pos + 1) begin
          m_dir = (k < m_pos); m_pos = k; m_st = 2;
          e_lsb = (k == 0) && m_dir;
          e_msb = (k == N - 1) && !m_dir;
        end else begin e_err = 1; e_code = 2; m_pos = k; end
      end else begin
        step = m_dir ? -1 : 1;
        if (m_pos + step < 0 || m_pos + step > N - 1) step = -step;
        nxt = m_pos + step;
        if (ok && k == nxt) begin
          e_lsb = (k == 0) && (step < 0);
          e_msb = (k == N - 1) && (step > 0);
          m_dir = (step < 0); m_pos = k;
          if (e_lsb) m_per = (m_per + 1) % (1 << PERIOD_W);
          if (m_st == 2) begin
            m_good = (m_good < 15) ? m_good + 1 : 15;
            if (m_good >= LOCK_CNT) m_st = 3;
          end
        end else begin
          e_err = 1; m_good = 0;
          if (!ok) begin e_code = 1; m_st = 0; end
          else begin
            e_code = (m_pos > 0 && m_pos < N - 1 && k == m_pos - step) ? 3 : 2;
            m_pos = k; m_st = 1;
          end
        end
      end
    end
    if (STK) begin
      if (clr) m_sticky = 3'b000;
      if (e_err) m_sticky[e_code-1] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos"}, pos, m_pos);
    chk({tag, ".dir"}, dir, m_dir);
    chk({tag, ".locked"}, locked, (m_st == 3));
    chk({tag, ".lsb_hit"}, lsb_hit, e_lsb);
    chk({tag, ".msb_hit"}, msb_hit, e_msb);
    chk({tag, ".period"}, period_count, m_per);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".err_code"}, err_code, e_code);
    chk({tag, ".sticky"}, err_sticky, m_sticky);
  endtask

  task automatic tick(input bit en, input bit [7:0] q, input bit clr, input string tag);
    ena = en; q_in = q; clr_err = clr;
    @(posedge clk);
    #1;
    model_step(en, q, clr);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  function automatic bit [7:0] legal_next();
    int s, n;
    bit [7:0] v;
    if (m_st == 0) n = $urandom_range(0, N - 1);
    else if (m_st == 1) n = (m_pos > 0) ? m_pos - 1 : m_pos + 1;
    else begin
      s = m_dir ? -1 : 1;
      if (m_pos + s < 0 || m_pos + s > N - 1) s = -s;
      n = m_pos + s;
    end
    v = 8'h01;
    return v << n;
  endfunction

  typedef struct {
    bit       en;
    bit [7:0] q;
    bit [2:0] pos;
    bit       dir;
    bit       lk;
    bit       lsb;
    bit       msb;
    bit [1:0] per;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int hits, lim;
    bit found;
    bit [7:0] r;
    tbl[0]  = '{1, 8'h80, 3'd7, 1, 0, 0, 0, 2'd0};
    tbl[1]  = '{1, 8'h40, 3'd6, 1, 0, 0, 0, 2'd0};
    tbl[2]  = '{1, 8'h20, 3'd5, 1, 0, 0, 0, 2'd0};
    tbl[3]  = '{1, 8'h10, 3'd4, 1, 0, 0, 0, 2'd0};
    tbl[4]  = '{1, 8'h08, 3'd3, 1, 0, 0, 0, 2'd0};
    tbl[5]  = '{1, 8'h04, 3'd2, 1, 1, 0, 0, 2'd0};
    tbl[6]  = '{1, 8'h02, 3'd1, 1, 1, 0, 0, 2'd0};
    tbl[7]  = '{1, 8'h01, 3'd0, 1, 1, 1, 0, 2'd1};
    tbl[8]  = '{1, 8'h02, 3'd1, 0, 1, 0, 0, 2'd1};
    tbl[9]  = '{1, 8'h04, 3'd2, 0, 1, 0, 0, 2'd1};
    tbl[10] = '{1, 8'h08, 3'd3, 0, 1, 0, 0, 2'd1};
    tbl[11] = '{1, 8'h10, 3'd4, 0, 1, 0, 0, 2'd1};
    tbl[12] = '{1, 8'h20, 3'd5, 0, 1, 0, 0, 2'd1};
    tbl[13] = '{1, 8'h40, 3'd6, 0, 1, 0, 0, 2'd1};
    tbl[14] = '{1, 8'h80, 3'd7, 0, 1, 0, 1, 2'd1};
    tbl[15] = '{1, 8'h40, 3'd6, 1, 1, 0, 0, 2'd1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].en, tbl[i].q, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.pos", i), pos, tbl[i].pos);
      chk($sformatf("tbl%0d.dir", i), dir, tbl[i].dir);
      chk($sformatf("tbl%0d.locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d.lsb", i), lsb_hit, tbl[i].lsb);
      chk($sformatf("tbl%0d.msb", i), msb_hit, tbl[i].msb);
      chk($sformatf("tbl%0d.period", i), period_count, tbl[i].per);
      chk($sformatf("tbl%0d.err", i), err, 1'b0);
    end

    // Three more periods wrap the 2-bit period counter back to 0.
    hits = 0;
    for (int i = 0; i < 60 && hits < 3; i++) begin
      tick(1'b1, legal_next(), 1'b0, "wrap");
      if (e_lsb) hits++;
    end
    chk("wrap.hits", hits, 3);
    chk("wrap.period", period_count, 0);

    // Reach LOCKED at pos 4 moving right, then a two-hot sample.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b1, legal_next(), 1'b0, "seek4");
      found = (m_st == 3 && m_pos == 4 && m_dir);
    end
    chk("seek4.found", found, 1);
    tick(1'b1, 8'h30, 1'b0, "twohot");
    chk("twohot.err", err, 1);
    chk("twohot.code", err_code, 2'b01);
    chk("twohot.locked", locked, 0);
    tick(1'b1, 8'h08, 1'b0, "reacq");
    chk("reacq.pos", pos, 3);
    chk("reacq.err", err, 0);

    // Relock, reach pos 5 moving right, then reverse away from an end.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b1, legal_next(), 1'b0, "seek5");
      found = (m_st == 3 && m_pos == 5 && m_dir);
    end
    chk("seek5.found", found, 1);
    tick(1'b1, 8'h40, 1'b0, "rev");
    chk("rev.code", err_code, 2'b11);
    chk("rev.pos", pos, 6);
    tick(1'b1, 8'h08, 1'b0, "jump");
    chk("jump.code", err_code, 2'b10);
    chk("jump.pos", pos, 3);

    // Ena low with garbage on the bus: everything holds, no pulses.
    for (int i = 0; i < 4; i++) tick(1'b1, legal_next(), 1'b0, "pre_hold");
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom);
      tick(1'b0, r, 1'b0, "hold");
    end

    // Reset mid-stream discards history.
    do_reset();
    chk("rst.period", period_count, 0);

    // Sticky flags: code 01 then code 11, then clear coinciding with a new error.
    tick(1'b1, 8'h03, 1'b0, "stk_hot");
    tick(1'b1, 8'h10, 1'b0, "stk_acq");
    tick(1'b1, 8'h08, 1'b0, "stk_trk");
    tick(1'b1, 8'h10, 1'b0, "stk_rev");
    chk("stk.code_rev", err_code, 2'b11);
    chk("stk.after_two", err_sticky, STK ? 3'b101 : 3'b000);
    tick(1'b1, 8'h00, 1'b1, "stk_clr_new");
    chk("stk.clr_with_err", err_sticky, STK ? 3'b001 : 3'b000);
    tick(1'b0, 8'h00, 1'b1, "stk_clr");
    chk("stk.cleared", err_sticky, 3'b000);

    // Randomized mix of legal walk, bus noise and idle cycles.
    for (int i = 0; i < 400; i++) begin
      lim = $urandom_range(0, 9);
      if (lim == 0)      r = 8'($urandom);
      else if (lim == 1) r = 8'h01 << $urandom_range(0, N - 1);
      else               r = legal_next();
      tick(lim != 9, r, ($urandom_range(0, 15) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
